// File: rtl/seg_scan_reader.sv
// seg_scan_reader: recovers hex digits from a multiplexed active-low 7-seg bus.
// Optional SEG_SYNC_EN adds a 2-flop synchronizer on S and AN.
module seg_scan_reader #(
  parameter int DIGITS = 3,
  parameter int STABLE = 4
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [6:0]          S,
  input  logic [DIGITS-1:0]   AN,
  output logic [4*DIGITS-1:0] D_OUT,
  output logic                VALID,
  output logic                BAD,
  output logic                BUSY
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SETTLE = 2'd1;
  localparam logic [1:0] HOLD   = 2'd2;
  localparam logic [7:0] STB    = 8'(STABLE);
  localparam bit         ONE    = (STABLE == 1);

  logic [6:0]          s_in;
  logic [DIGITS-1:0]   an_in;

`ifdef SEG_SYNC_EN
  logic [6:0]          s_m, s_q;
  logic [DIGITS-1:0]   an_m, an_q;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      s_m  <= '1;
      s_q  <= '1;
      an_m <= '1;
      an_q <= '1;
    end else begin
      s_m  <= S;
      s_q  <= s_m;
      an_m <= AN;
      an_q <= an_m;
    end
  end

  assign s_in  = s_q;
  assign an_in = an_q;
`else
  assign s_in  = S;
  assign an_in = AN;
`endif

  logic [1:0]          st, st_n;
  logic [7:0]          cnt, cnt_n;
  logic [6:0]          s_smp;
  logic [DIGITS-1:0]   an_smp;
  logic [DIGITS-1:0]   inv;
  logic                sel, same, cap;
  logic [3:0]          nib;
  logic                nib_bad;
  logic [DIGITS-1:0]   mask, mask_n;
  logic [4*DIGITS-1:0] stg, stg_n;
  logic                fbad, fbad_n;
  logic                full;

  // one-hot test on the inverted strobes: exactly one digit selected
  assign inv  = ~an_in;
  assign sel  = (inv != '0) && ((inv & (inv - DIGITS'(1))) == '0);
  assign same = (s_in == s_smp) && (an_in == an_smp);
  assign full = &mask;
  assign BUSY = (|mask) & ~full;

  always_comb begin
    nib     = 4'h0;
    nib_bad = 1'b0;
    unique case (s_in)
      7'h40: nib = 4'h0;
      7'h79: nib = 4'h1;
      7'h24: nib = 4'h2;
      7'h30: nib = 4'h3;
      7'h19: nib = 4'h4;
      7'h12: nib = 4'h5;
      7'h02: nib = 4'h6;
      7'h78: nib = 4'h7;
      7'h00: nib = 4'h8;
      7'h18: nib = 4'h9;
      7'h08: nib = 4'hA;
      7'h03: nib = 4'hB;
      7'h46: nib = 4'hC;
      7'h21: nib = 4'hD;
      7'h06: nib = 4'hE;
      7'h0E: nib = 4'hF;
      default: nib_bad = 1'b1;
    endcase
  end

  always_comb begin
    st_n  = st;
    cnt_n = cnt;
    cap   = 1'b0;
    unique case (st)
      SETTLE: begin
        cnt_n = same ? cnt + 8'd1 : 8'd1;
        if (!sel) begin
          cnt_n = '0;
          st_n  = IDLE;
        end else if (cnt_n >= STB) begin
          cap  = 1'b1;
          st_n = HOLD;
        end
      end
      HOLD: begin
        if (!same) begin
          cnt_n = sel ? 8'd1 : 8'd0;
          cap   = sel & ONE;
          st_n  = !sel ? IDLE : (ONE ? HOLD : SETTLE);
        end
      end
      default: begin
        cnt_n = sel ? 8'd1 : 8'd0;
        cap   = sel & ONE;
        st_n  = !sel ? IDLE : (ONE ? HOLD : SETTLE);
      end
    endcase
  end

  // a completing frame is cleared first, so a same-cycle capture opens the next one
  always_comb begin
    mask_n = full ? '0 : mask;
    stg_n  = full ? '0 : stg;
    fbad_n = full ? 1'b0 : fbad;
    if (cap && ((mask_n & inv) == '0)) begin
      mask_n = mask_n | inv;
      fbad_n = fbad_n | nib_bad;
      for (int k = 0; k < DIGITS; k++) begin
        if (inv[k]) stg_n[4*k +: 4] = nib_bad ? 4'h0 : nib;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      st     <= IDLE;
      cnt    <= '0;
      s_smp  <= '1;
      an_smp <= '1;
      mask   <= '0;
      stg    <= '0;
      fbad   <= 1'b0;
      D_OUT  <= '0;
      VALID  <= 1'b0;
      BAD    <= 1'b0;
    end else begin
      st     <= st_n;
      cnt    <= cnt_n;
      s_smp  <= s_in;
      an_smp <= an_in;
      mask   <= mask_n;
      stg    <= stg_n;
      fbad   <= fbad_n;
      VALID  <= full;
      if (full) begin
        D_OUT <= stg;
        BAD   <= fbad;
      end
    end
  end

endmodule
